keycode_capture: RTL and testbench
==================================

// Module: keycode_capture
// PURPOSE
//  Sits directly downstream of the 9-input priority encoder (4-bit code, 1..9 = highest
//  active input, 0 = none). Debounces the code and registers one event per press/release
//  cycle. Queues accepted codes in a small FIFO and presents them on a valid/ready interface
//  to the consumer (display / command logic).
// PARAMETERS
//  STABLE_CYC  4  consecutive equal samples needed to accept a press or a release (>=2)
//  DEPTH       4  FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1                 single clock; all state updates on rising edge
//  rst        in   1                 asynchronous, active-high reset
//  code_in    in   4                 encoder output; 0 = no key, 1..9 = key, 10..15 invalid
//  out_code   out  4                 FIFO head code; 0 when FIFO empty
//  out_valid  out  1                 FIFO non-empty
//  out_ready  in   1                 consumer accepts head when out_valid && out_ready
//  count      out  $clog2(DEPTH)+1   entries currently held, 0..DEPTH
//  overflow   out  1                 1-cycle pulse: accepted code dropped because FIFO full
// BEHAVIOUR
//  Reset (async assert, sync use after deassert): FSM=IDLE, counters 0, FIFO empty;
//   out_code=0, out_valid=0, count=0, overflow=0. Reset mid-press discards everything.
//  Input classing: code_in 10..15 is treated exactly as 0 ("no key") everywhere.
//  FSM (registered, evaluated on each edge using sampled code_in):
//   IDLE : code_in==0 -> stay. code_in!=0 -> cand<=code_in, scnt<=1, go QUAL.
//   QUAL : code_in==0 -> IDLE. code_in!=cand -> cand<=code_in, scnt<=1 (restart).
//          code_in==cand: if scnt==STABLE_CYC-1 -> push cand, go HELD; else scnt++.
//   HELD : code_in!=0 -> rcnt<=0 (any key, incl. a different one, is ignored).
//          code_in==0: if rcnt==STABLE_CYC-1 -> go IDLE; else rcnt++.
//  Latency: first nonzero sample at edge k, equal samples at edges k..k+STABLE_CYC-1 ->
//   entry written at edge k+STABLE_CYC-1; out_valid=1 after that edge if FIFO was empty.
//   No combinational fall-through from code_in to outputs.
//  A new press is only accepted after STABLE_CYC consecutive zero samples in HELD;
//   holding a key produces exactly one entry.
//  FIFO: wr/rd pointers $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full when count==DEPTH.
//   pop = out_valid && out_ready; push = FSM accept.
//   push && !full -> write. push && full && !pop -> drop, overflow=1 next cycle only.
//   push && full && pop -> both happen, no overflow, count unchanged.
//   push && empty -> out_valid next cycle (pop same cycle impossible: out_valid=0).
//   pop && !push -> count-1; out_code shows next entry (or 0) after the edge.
//  out_code, out_valid, count are registered-state derived; stable while !out_ready.
//  out_ready while !out_valid has no effect.
// TESTING
//  1 Reset, code_in=5 for STABLE_CYC cycles, out_ready=0 -> out_valid=1, out_code=5,
//    count=1 at edge k+3 (STABLE_CYC=4); hold 5 for 20 more cycles -> count stays 1.
//  2 Bounce: 3,0,3,3,0,3,3,3,3 -> exactly one entry code 3, accepted on last sample;
//    3,3,7,7,7,7 -> one entry code 7 (restart on change).
//  3 Fill: 5 clean press/release pairs codes 1..5, out_ready=0 -> count=4, head=1,
//    overflow pulses once on code 5; drain with out_ready=1 -> 1,2,3,4 then out_code=0.
//  4 FIFO full, out_ready=1 on the accept cycle of a new code 9 -> no overflow,
//    count stays 4, tail entry = 9.
//  5 code_in=12 held 10 cycles -> no entry; assert rst during QUAL with code 6 ->
//    outputs 0 immediately, no entry for 6 after release of rst until new STABLE_CYC run.

Source files
------------

// File: rtl/keycode_capture.sv
// keycode_capture: debounces priority-encoder key codes, one event per press, queued in a small FIFO
module keycode_capture #(
    parameter int STABLE_CYC = 4,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 code_in,
    output logic [3:0]                 out_code,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STABLE_CYC);
    localparam logic [SW-1:0] LAST = SW'(STABLE_CYC - 1);
    typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;
    state_t state, state_n;
    logic [3:0] cand, cand_n;
    logic [SW-1:0] scnt, scnt_n, rcnt, rcnt_n;
    logic [3:0] key;
    logic push, pop, full, wr;
    logic [3:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr;
    // invalid encoder codes 10..15 behave exactly like "no key"
    assign key = (code_in > 4'd9) ? 4'd0 : code_in;
    always_comb begin
        state_n = state;
        cand_n  = cand;
        scnt_n  = scnt;
        rcnt_n  = rcnt;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (key != 4'd0) begin
                    cand_n  = key;
                    scnt_n  = SW'(1);
                    state_n = QUAL;
                end
            end
            QUAL: begin
                if (key == 4'd0) begin
                    state_n = IDLE;
                end else if (key != cand) begin
                    cand_n = key;
                    scnt_n = SW'(1);
                end else if (scnt == LAST) begin
                    push    = 1'b1;
                    rcnt_n  = '0;
                    state_n = HELD;
                end else begin
                    scnt_n = scnt + SW'(1);
                end
            end
            HELD: begin
                if (key != 4'd0)
                    rcnt_n = '0;
                else if (rcnt == LAST)
                    state_n = IDLE;
                else
                    rcnt_n = rcnt + SW'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            scnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            scnt  <= scnt_n;
            rcnt  <= rcnt_n;
        end
    end
    assign count     = wr_ptr - rd_ptr;
    assign out_valid = count != '0;
    assign full      = count == CW'(DEPTH);
    assign pop       = out_valid && out_ready;
    // a simultaneous pop frees the slot, so a full FIFO can still take the push
    assign wr        = push && (!full || pop);
    assign out_code  = out_valid ? mem[rd_ptr[AW-1:0]] : 4'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr[AW-1:0]] <= cand;
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + CW'(1);
            overflow <= push && full && !pop;
        end
    end
endmodule

// File: tb/tb_keycode_capture.sv
// tb_keycode_capture: vector table, corner sequences and random run against a run-length reference model
module tb_keycode_capture;
    localparam int SC = 4;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] code_in = 4'd0;
    logic out_ready = 1'b0;
    logic [3:0] out_code;
    logic out_valid;
    logic [2:0] count;
    logic overflow;
    int checks = 0;
    int errors = 0;
    keycode_capture #(.STABLE_CYC(SC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .out_code(out_code),
        .out_valid(out_valid), .out_ready(out_ready), .count(count), .overflow(overflow)
    );
    always #5 clk = ~clk;
    typedef struct {
        int code;
        bit ready;
        bit v;
        int oc;
        int cnt;
        bit ovf;
    } vec_t;
    vec_t vecs[$];
    int q[$];
    bit armed;
    int run_val, run_len;
    bit m_ovf;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        armed = 1'b1;
        run_val = 0;
        run_len = 0;
        m_ovf = 1'b0;
    endtask
    // acceptance = STABLE_CYC identical nonzero samples while armed; re-arm after STABLE_CYC zeros
    task automatic model_edge(input int c, input bit r);
        int k;
        bit acc, p;
        k = (c > 9) ? 0 : c;
        if (k == run_val) run_len++;
        else begin
            run_val = k;
            run_len = 1;
        end
        acc = 1'b0;
        if (armed && k != 0 && run_len == SC) begin
            acc = 1'b1;
            armed = 1'b0;
        end else if (!armed && k == 0 && run_len == SC) begin
            armed = 1'b1;
        end
        p = q.size() > 0 && r;
        m_ovf = 1'b0;
        if (p) void'(q.pop_front());
        if (acc) begin
            if (q.size() < DEPTH) q.push_back(k);
            else m_ovf = 1'b1;
        end
    endtask
    task automatic check_model(input string tag);
        chk({tag, "_valid"}, out_valid, q.size() > 0);
        chk({tag, "_code"}, out_code, q.size() > 0 ? q[0] : 0);
        chk({tag, "_count"}, count, q.size());
        chk({tag, "_ovf"}, overflow, m_ovf);
    endtask
    task automatic step(input int c, input bit r);
        code_in = 4'(c);
        out_ready = r;
        @(posedge clk);
        model_edge(c, r);
        #1;
        check_model("model");
    endtask
    task automatic press(input int c);
        repeat (SC) step(c, 1'b0);
        repeat (SC) step(0, 1'b0);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        code_in = 4'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask
    function automatic void add(int c, bit r, bit v, int oc, int cnt, bit ovf);
        vec_t e;
        e.code = c; e.ready = r; e.v = v; e.oc = oc; e.cnt = cnt; e.ovf = ovf;
        vecs.push_back(e);
    endfunction
    initial begin
        repeat (3) add(5, 0, 0, 0, 0, 0);
        add(5, 0, 1, 5, 1, 0);
        repeat (20) add(5, 0, 1, 5, 1, 0);
        repeat (4) add(0, 0, 1, 5, 1, 0);
        add(0, 1, 0, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0); add(3, 0, 0, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
        repeat (3) add(3, 0, 0, 0, 0, 0);
        add(3, 0, 1, 3, 1, 0);
        repeat (4) add(0, 0, 1, 3, 1, 0);
        add(3, 0, 1, 3, 1, 0); add(3, 0, 1, 3, 1, 0);
        repeat (3) add(7, 0, 1, 3, 1, 0);
        add(7, 0, 1, 3, 2, 0);
        add(0, 1, 1, 7, 1, 0);
        repeat (3) add(0, 1, 0, 0, 0, 0);
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_code", out_code, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        foreach (vecs[i]) begin
            step(vecs[i].code, vecs[i].ready);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].v);
            chk($sformatf("vec%0d_code", i), out_code, vecs[i].oc);
            chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
        end
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            repeat (SC) step(c, 1'b0);
            chk($sformatf("fill_ovf%0d", c), overflow, c == 5);
            step(0, 1'b0);
            chk("fill_ovf_clear", overflow, 0);
            repeat (SC - 1) step(0, 1'b0);
        end
        chk("fill_count", count, 4);
        for (int c = 1; c <= 4; c++) begin
            chk("drain_code", out_code, c);
            step(0, 1'b1);
        end
        chk("drain_empty_code", out_code, 0);
        chk("drain_empty_valid", out_valid, 0);
        for (int c = 1; c <= 4; c++) press(c);
        repeat (SC - 1) step(9, 1'b0);
        step(9, 1'b1);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_count", count, 4);
        chk("fullpop_head", out_code, 2);
        repeat (SC) step(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("fullpop_drain", out_code, i == 3 ? 9 : i + 2);
            step(0, 1'b1);
        end
        repeat (10) step(12, 1'b0);
        chk("invalid_count", count, 0);
        press(2);
        chk("pre_rst_count", count, 1);
        step(6, 1'b0);
        step(6, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_code", out_code, 0);
        chk("async_rst_count", count, 0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        repeat (SC - 1) step(6, 1'b0);
        chk("post_rst_none", count, 0);
        step(6, 1'b0);
        chk("post_rst_count", count, 1);
        chk("post_rst_code", out_code, 6);
        repeat (SC) step(0, 1'b1);
        for (int n = 0; n < 3000;) begin
            int v, len;
            bit r;
            v = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 3) == 0;
                step(v, r);
                n++;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
